// File: rtl/orv64_typedef_pkg.sv
// Shared orv64 ITB types: trace record layout, write address and capture state.
// Record bits [60:39] carry a cycle stamp only when ORV64_ITB_TIMESTAMP_EN is defined.
package orv64_typedef_pkg;

   localparam int ORV64_ITB_ADDR_W = 8;
   localparam int ORV64_ITB_PC_W   = 39;
   localparam int ORV64_ITB_TS_W   = 22;

   localparam int ORV64_ITB_TRAP_BIT  = 63;
   localparam int ORV64_ITB_TAKEN_BIT = 62;
   localparam int ORV64_ITB_BR_BIT    = 61;
   localparam int ORV64_ITB_TS_LSB    = 39;
   localparam int ORV64_ITB_PC_LSB    = 0;

   typedef struct packed {
      logic                      trap;
      logic                      taken;
      logic                      is_br;
      logic [ORV64_ITB_TS_W-1:0] ts;
      logic [ORV64_ITB_PC_W-1:0] pc;
   } orv64_itb_data_t;

   typedef logic [ORV64_ITB_ADDR_W-1:0] orv64_itb_addr_t;

   typedef enum logic [1:0] {
      ITB_IDLE   = 2'd0,
      ITB_ARMED  = 2'd1,
      ITB_POST   = 2'd2,
      ITB_FROZEN = 2'd3
   } orv64_itb_state_e;

endpackage

// File: rtl/orv64_itb_ctrl_if.sv
// Retire/config/ITB-port bundle of the ITB capture controller.
// master: core + CSR side; slave: the capture controller.
interface orv64_itb_ctrl_if
   import orv64_typedef_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int PC_W   = 39,
   parameter int DROP_W = 16
) ();

   logic              retire_valid;
   logic [PC_W-1:0]   retire_pc;
   logic              retire_is_br;
   logic              retire_taken;
   logic              retire_trap;
   logic              dbg_en;
   logic              cfg_itb_en;
   logic              cfg_itb_sel;
   logic              cfg_itb_clr;
   logic              cfg_trig_en;
   logic [PC_W-1:0]   cfg_trig_pc;
   logic [ADDR_W-1:0] cfg_post_cnt;

   logic              itb_en;
   orv64_itb_data_t   itb_data;
   logic [ADDR_W-1:0] itb_addr;
   logic [ADDR_W-1:0] itb_wptr;
   logic              itb_wrapped;
   orv64_itb_state_e  itb_state;
   logic [DROP_W-1:0] itb_drop_cnt;

   modport master (
      output retire_valid, retire_pc, retire_is_br,
      output retire_taken, retire_trap, dbg_en,
      output cfg_itb_en, cfg_itb_sel, cfg_itb_clr,
      output cfg_trig_en, cfg_trig_pc, cfg_post_cnt,
      input  itb_en, itb_data, itb_addr, itb_wptr,
      input  itb_wrapped, itb_state, itb_drop_cnt
   );

   modport slave (
      input  retire_valid, retire_pc, retire_is_br,
      input  retire_taken, retire_trap, dbg_en,
      input  cfg_itb_en, cfg_itb_sel, cfg_itb_clr,
      input  cfg_trig_en, cfg_trig_pc, cfg_post_cnt,
      output itb_en, itb_data, itb_addr, itb_wptr,
      output itb_wrapped, itb_state, itb_drop_cnt
   );

endinterface

// File: rtl/orv64_itb_rec_fmt.sv
// Retire filter and trace-record packer for the ITB (purely combinational).
module orv64_itb_rec_fmt
   import orv64_typedef_pkg::*;
#(
   parameter int PC_W = 39
) (
   input  logic                      valid,
   input  logic [PC_W-1:0]           pc,
   input  logic                      is_br,
   input  logic                      taken,
   input  logic                      trap,
   input  logic                      sel,
   input  logic [ORV64_ITB_TS_W-1:0] ts,
   output logic                      qual,
   output orv64_itb_data_t           rec
);

   logic xfer;

   always_comb begin
      xfer = sel ? (is_br & taken) : is_br;
      qual = valid & (xfer | trap);
   end

   always_comb begin
      rec       = '0;
      rec.trap  = trap;
      rec.taken = taken;
      rec.is_br = is_br;
      rec.ts    = ts;
      rec.pc    = pc;
   end

endmodule

// File: rtl/orv64_itb_ctrl.sv
// ITB capture controller: arm/trigger/post/freeze FSM, circular write pointer, drop count.
// Optional ORV64_ITB_TIMESTAMP_EN: free-running 22-bit cycle stamp in each record.
module orv64_itb_ctrl
   import orv64_typedef_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int PC_W   = 39,
   parameter int DROP_W = 16
) (
   input logic             clk,
   input logic             rst,
   orv64_itb_ctrl_if.slave bus
);

   orv64_itb_state_e  state_q, state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic              wrapped_q, wrapped_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic [ADDR_W-1:0] post_q, post_d;
   logic              en_q, en_d;
   logic              itb_en_q, itb_en_d;
   orv64_itb_data_t   itb_data_q, itb_data_d;
   logic [ADDR_W-1:0] itb_addr_q, itb_addr_d;

   logic [ORV64_ITB_TS_W-1:0] ts;
   logic                      qual;
   orv64_itb_data_t           rec_data;

`ifdef ORV64_ITB_TIMESTAMP_EN
   logic [ORV64_ITB_TS_W-1:0] ts_q, ts_d;

   always_comb ts_d = ts_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ts_q <= '0;
      else     ts_q <= ts_d;
   end

   assign ts = ts_q;
`else
   assign ts = '0;
`endif

   orv64_itb_rec_fmt #(
      .PC_W (PC_W)
   ) u_fmt (
      .valid (bus.retire_valid),
      .pc    (bus.retire_pc),
      .is_br (bus.retire_is_br),
      .taken (bus.retire_taken),
      .trap  (bus.retire_trap),
      .sel   (bus.cfg_itb_sel),
      .ts    (ts),
      .qual  (qual),
      .rec   (rec_data)
   );

   logic en_rise;
   logic capturing;
   logic trig_hit;
   logic rec;
   logic wr;
   logic drop;

   always_comb begin
      en_rise   = bus.cfg_itb_en & ~en_q;
      capturing = (state_q == ITB_ARMED) | (state_q == ITB_POST);
      trig_hit  = (state_q == ITB_ARMED) & bus.retire_valid &
                  bus.cfg_trig_en &
                  (bus.retire_pc == bus.cfg_trig_pc);
      rec       = capturing & (qual | trig_hit);
      wr        = rec & ~bus.dbg_en;
      drop      = rec & bus.dbg_en;
   end

   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      wrapped_d  = wrapped_q;
      drop_d     = drop_q;
      post_d     = post_q;
      en_d       = bus.cfg_itb_en;
      itb_en_d   = 1'b0;
      itb_data_d = itb_data_q;
      itb_addr_d = itb_addr_q;

      if (bus.cfg_itb_clr) begin
         wptr_d    = '0;
         wrapped_d = 1'b0;
         drop_d    = '0;
         post_d    = '0;
         state_d   = bus.cfg_itb_en ? ITB_ARMED : ITB_IDLE;
      end else if (!bus.cfg_itb_en) begin
         state_d = ITB_IDLE;
      end else if (en_rise) begin
         state_d   = ITB_ARMED;
         wptr_d    = '0;
         wrapped_d = 1'b0;
      end else if (capturing) begin
         if (wr) begin
            itb_en_d   = 1'b1;
            itb_data_d = rec_data;
            itb_addr_d = wptr_q;
            wptr_d     = wptr_q + 1'b1;
            if (&wptr_q) wrapped_d = 1'b1;
         end
         if (drop && !(&drop_q)) drop_d = drop_q + 1'b1;
         // A written trigger record is the first of the post-trigger records.
         if (trig_hit) begin
            if (wr && bus.cfg_post_cnt == '0) begin
               state_d = ITB_FROZEN;
            end else begin
               state_d = ITB_POST;
               post_d  = wr ? bus.cfg_post_cnt - 1'b1 : bus.cfg_post_cnt;
            end
         end else if (state_q == ITB_POST && wr) begin
            if (post_q == '0) state_d = ITB_FROZEN;
            else              post_d  = post_q - 1'b1;
         end
      end
   end

   // en_q resets high so a level already asserted through reset is not a rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ITB_IDLE;
         wptr_q     <= '0;
         wrapped_q  <= 1'b0;
         drop_q     <= '0;
         post_q     <= '0;
         en_q       <= 1'b1;
         itb_en_q   <= 1'b0;
         itb_data_q <= '0;
         itb_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         wrapped_q  <= wrapped_d;
         drop_q     <= drop_d;
         post_q     <= post_d;
         en_q       <= en_d;
         itb_en_q   <= itb_en_d;
         itb_data_q <= itb_data_d;
         itb_addr_q <= itb_addr_d;
      end
   end

   assign bus.itb_en       = itb_en_q;
   assign bus.itb_data     = itb_data_q;
   assign bus.itb_addr     = itb_addr_q;
   assign bus.itb_wptr     = wptr_q;
   assign bus.itb_wrapped  = wrapped_q;
   assign bus.itb_state    = state_q;
   assign bus.itb_drop_cnt = drop_q;

endmodule
